// File: rtl/mem_wb_pkg.sv
// Shared encodings and helpers for the MEM/WB stage: access size codes,
// FSM states, byte-enable generation and load lane extraction.
package mem_wb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Byte-enable mask for a 64-bit lane set; narrower datapaths use the low bits.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr,
                                         input logic wide);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = (addr[1:0] != 2'b00);
      default: bad = !wide || (addr != 3'b000);
    endcase
    return bad;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic        [63:0] sh;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] s32;
    logic        [63:0] ext;
    sh  = word >> {off, 3'b000};
    s8  = sh[7:0];
    s16 = sh[15:0];
    s32 = sh[31:0];
    case (size)
      SZ_B:    ext = uns ? 64'(sh[7:0])  : 64'(s8);
      SZ_H:    ext = uns ? 64'(sh[15:0]) : 64'(s16);
      SZ_W:    ext = uns ? 64'(sh[31:0]) : 64'(s32);
      default: ext = sh;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/mem_wb_stage_param_data_mem_be.sv
// Byte-enable data memory: synchronous write per byte lane, asynchronous read.
module data_mem_be
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage_param.sv
// MEM/WB stage: data memory access with optional multi-cycle latency, followed by
// the write-back register set that feeds the register file and forwarding logic.
module mem_wb_stage_param
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] reg_dst,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic                  flush,
  output logic                  busy,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg_dst,
  output logic                  wb_reg_write,
  output logic                  misalign_err
);

  localparam int         NB   = DATA_W / 8;
  localparam int         L    = $clog2(NB);
  localparam logic       WIDE = (DATA_W == 64);
  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic       HAS_LAT = (MEM_LAT != 0);

  state_t     state, state_nxt;
  logic [2:0] cnt;

  // Request captured on the accept edge; replayed while waiting on memory.
  logic [DATA_W-1:0]     addr_p0;
  logic [DATA_W-1:0]     sdata_p0;
  logic [REG_ADDR_W-1:0] dst_p0;
  logic                  rw_p0, rd_p0, wr_p0, m2r_p0, uns_p0;
  logic [1:0]            size_p0;

  logic [DATA_W-1:0]     cur_addr, cur_sdata;
  logic [REG_ADDR_W-1:0] cur_dst;
  logic                  cur_rw, cur_rd, cur_wr, cur_m2r, cur_uns;
  logic [1:0]            cur_size;

  logic                  in_wait, accept, cur_err, go_wait, fin_wait, complete;
  logic                  mem_we, sel_load, wb_rw_nxt;
  logic [2:0]            cur_off;
  logic [ADDR_W-1:0]     widx;
  logic [NB-1:0]         be;
  logic [DATA_W-1:0]     wdata, rdata, load_val, wb_data_nxt;

  assign in_wait = (state == WAIT);
  assign busy    = in_wait;
  assign accept  = (state == IDLE) && in_valid && !flush;

  always_comb begin
    cur_addr  = alu_out;
    cur_sdata = store_data;
    cur_dst   = reg_dst;
    cur_rw    = reg_write;
    cur_rd    = mem_read;
    cur_wr    = mem_write;
    cur_m2r   = mem_to_reg;
    cur_size  = mem_size;
    cur_uns   = mem_unsigned;
    if (in_wait) begin
      cur_addr  = addr_p0;
      cur_sdata = sdata_p0;
      cur_dst   = dst_p0;
      cur_rw    = rw_p0;
      cur_rd    = rd_p0;
      cur_wr    = wr_p0;
      cur_m2r   = m2r_p0;
      cur_size  = size_p0;
      cur_uns   = uns_p0;
    end
  end

  assign cur_off  = 3'(cur_addr[L-1:0]);
  assign widx     = cur_addr[ADDR_W+L-1:L];
  assign cur_err  = (cur_rd || cur_wr) && is_misaligned(cur_size, cur_addr[2:0], WIDE);

  // Misaligned ops never touch memory, so they bypass the wait state.
  assign go_wait  = accept && (cur_rd || cur_wr) && !cur_err && HAS_LAT;
  assign fin_wait = in_wait && (cnt == 3'd1) && !flush;
  assign complete = (accept && !go_wait) || fin_wait;
  assign mem_we   = complete && cur_wr && !cur_err;

  assign be    = NB'(be_mask(cur_size, cur_off));
  assign wdata = DATA_W'(64'(cur_sdata) << {cur_off, 3'b000});

  data_mem_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (be),
    .addr  (widx),
    .wdata (wdata),
    .rdata (rdata)
  );

  // A simultaneous read+write is treated as a store; write-back then carries alu_out.
  assign load_val    = DATA_W'(load_extract(64'(rdata), cur_off, cur_size, cur_uns));
  assign sel_load    = cur_rd && !cur_wr && cur_m2r && !cur_err;
  assign wb_data_nxt = sel_load ? load_val : cur_addr;
  assign wb_rw_nxt   = cur_rw && !cur_err && (cur_dst != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_wait) state_nxt = WAIT;
      WAIT:    if (flush || cnt == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= 3'd0;
    else if (flush)              cnt <= 3'd0;
    else if (go_wait)            cnt <= LAT;
    else if (in_wait && cnt != 3'd0) cnt <= cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= alu_out;
      sdata_p0 <= store_data;
      dst_p0   <= reg_dst;
      rw_p0    <= reg_write;
      rd_p0    <= mem_read;
      wr_p0    <= mem_write;
      m2r_p0   <= mem_to_reg;
      size_p0  <= mem_size;
      uns_p0   <= mem_unsigned;
    end
  end

  // Write-back register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_reg_dst   <= '0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
    end else if (complete) begin
      wb_valid     <= 1'b1;
      wb_data      <= wb_data_nxt;
      wb_reg_dst   <= cur_dst;
      wb_reg_write <= wb_rw_nxt;
      misalign_err <= cur_err;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_param.sv
// Bench for mem_wb_stage_param: one zero-latency and one three-cycle-latency
// instance, selected by sel, with a write-back scoreboard.
module tb_mem_wb_stage_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, in_valid, flush;
  logic [31:0] alu_out, store_data;
  logic [4:0]  reg_dst;
  logic        reg_write, mem_read, mem_write, mem_to_reg, mem_unsigned;
  logic [1:0]  mem_size;

  logic        iv0, iv3, fl0, fl3;
  logic        busy0, valid0, rw0, err0, busy3, valid3, rw3, err3;
  logic [31:0] data0, data3;
  logic [4:0]  dst0, dst3;
  logic        o_busy, o_valid, o_rw, o_err;
  logic [31:0] o_data;
  logic [4:0]  o_dst;

  assign iv0 = in_valid & ~sel;
  assign iv3 = in_valid & sel;
  assign fl0 = flush & ~sel;
  assign fl3 = flush & sel;

  assign o_busy  = sel ? busy3  : busy0;
  assign o_valid = sel ? valid3 : valid0;
  assign o_data  = sel ? data3  : data0;
  assign o_dst   = sel ? dst3   : dst0;
  assign o_rw    = sel ? rw3    : rw0;
  assign o_err   = sel ? err3   : err0;

  mem_wb_stage_param #(.DATA_W(32), .ADDR_W(10), .REG_ADDR_W(5), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .alu_out(alu_out), .store_data(store_data),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(fl0),
    .busy(busy0), .wb_valid(valid0), .wb_data(data0), .wb_reg_dst(dst0),
    .wb_reg_write(rw0), .misalign_err(err0));

  mem_wb_stage_param #(.DATA_W(32), .ADDR_W(10), .REG_ADDR_W(5), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .alu_out(alu_out), .store_data(store_data),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(fl3),
    .busy(busy3), .wb_valid(valid3), .wb_data(data3), .wb_reg_dst(dst3),
    .wb_reg_write(rw3), .misalign_err(err3));

  typedef struct {
    logic [31:0] d;
    logic [4:0]  dst;
    logic        rw;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] dst, input logic rw, input logic err);
    exp_t e;
    e.d = d; e.dst = dst; e.rw = rw; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] dst,
                         input logic rw, input logic rd, input logic wr, input logic m2r,
                         input logic [1:0] sz, input logic uns);
    alu_out = a; store_data = sd; reg_dst = dst; reg_write = rw; mem_read = rd;
    mem_write = wr; mem_to_reg = m2r; mem_size = sz; mem_unsigned = uns;
  endtask

  // Present one instruction for a single accepting edge; returns on the next negedge.
  task automatic op(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] dst,
                    input logic rw, input logic rd, input logic wr, input logic m2r,
                    input logic [1:0] sz, input logic uns);
    int g;
    g = 0;
    set_req(a, sd, dst, rw, rd, wr, m2r, sz, uns);
    in_valid = 1'b1;
    while (o_busy === 1'b1 && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int bound);
    int   n;
    exp_t e;
    n = 0;
    while (o_valid !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    check({tag, "_vld"}, 64'(o_valid), 64'd1);
    if (o_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(o_data), 64'(e.d));
      check({tag, "_dst"},  64'(o_dst),  64'(e.dst));
      check({tag, "_rw"},   64'(o_rw),   64'(e.rw));
      check({tag, "_err"},  64'(o_err),  64'(e.err));
    end
  endtask

  initial begin
    int busy_cnt, n;
    rst = 1'b0; sel = 1'b0; in_valid = 1'b0; flush = 1'b0;
    set_req(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    #1;
    check("rst_vld0",  64'(valid0), 64'd0);
    check("rst_data0", 64'(data0),  64'd0);
    check("rst_rw0",   64'(rw0),    64'd0);
    check("rst_err0",  64'(err0),   64'd0);
    check("rst_busy3", 64'(busy3),  64'd0);
    check("rst_vld3",  64'(valid3), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-latency instance
    push(32'h10, 5'd0, 1'b0, 1'b0);
    op(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0); collect("sw10", 12);
    push(32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
    op(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("lw10", 12);
    push(32'hFFFFFFDE, 5'd6, 1'b1, 1'b0);
    op(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0); collect("lb13", 12);
    push(32'h000000DE, 5'd6, 1'b1, 1'b0);
    op(32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1); collect("lbu13", 12);
    push(32'hFFFFDEAD, 5'd6, 1'b1, 1'b0);
    op(32'h12, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0); collect("lh12", 12);
    push(32'h0000BEEF, 5'd6, 1'b1, 1'b0);
    op(32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1); collect("lhu10", 12);

    push(32'h11, 5'd7, 1'b0, 1'b1);
    op(32'h11, 32'h11111111, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0); collect("sw11_mis", 12);
    @(negedge clk);
    check("mis_pulse", 64'(o_err), 64'd0);
    check("mis_vld_drop", 64'(o_valid), 64'd0);
    push(32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
    op(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("lw10_after", 12);

    push(32'h11, 5'd0, 1'b0, 1'b0);
    op(32'h11, 32'hFFFFFF55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0); collect("sb11", 12);
    push(32'hDEAD55EF, 5'd5, 1'b1, 1'b0);
    op(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("lw10_sb", 12);
    push(32'h13, 5'd8, 1'b0, 1'b1);
    op(32'h13, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0); collect("lh13_mis", 12);
    push(32'h10, 5'd8, 1'b0, 1'b1);
    op(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0); collect("ld_on32", 12);

    push(32'h14, 5'd9, 1'b1, 1'b0);
    op(32'h14, 32'hCAFEF00D, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0); collect("rdwr14", 12);
    push(32'hCAFEF00D, 5'd9, 1'b1, 1'b0);
    op(32'h14, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("lw14", 12);
    push(32'h12345, 5'd10, 1'b1, 1'b0);
    op(32'h12345, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0); collect("alu", 12);
    push(32'h777, 5'd0, 1'b0, 1'b0);
    op(32'h777, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0); collect("alu_r0", 12);
    push(32'hDEAD55EF, 5'd5, 1'b1, 1'b0);
    op(32'h1010, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("lw_wrap", 12);

    // Three-cycle latency instance
    sel = 1'b1;
    @(negedge clk);
    push(32'h20, 5'd0, 1'b0, 1'b0);
    set_req(32'h20, 32'hAAAA5555, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_bubble", 64'(o_valid), 64'd0);
    push(32'hAAAA5555, 5'd11, 1'b1, 1'b0);
    set_req(32'h20, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    busy_cnt = 0; n = 0;
    while (o_busy === 1'b1 && n < 20) begin busy_cnt++; @(negedge clk); n++; end
    check("lat_busy_cycles", 64'(busy_cnt), 64'd3);
    collect("lat_a", 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_b_accept", 64'(o_busy), 64'd1);
    collect("lat_b", 10);

    set_req(32'h20, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_idle", 64'(o_busy), 64'd0);
    check("fl_vld", 64'(o_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("fl_vld_later", 64'(o_valid), 64'd0);
    push(32'hAAAA5555, 5'd13, 1'b1, 1'b0);
    op(32'h20, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("fl_old", 10);

    op(32'h20, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    check("rw_busy", 64'(o_busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy3),  64'd0);
    check("arst_vld",  64'(valid3), 64'd0);
    check("arst_data", 64'(data3),  64'd0);
    check("arst_rw",   64'(rw3),    64'd0);
    check("arst_err",  64'(err3),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(32'hAAAA5555, 5'd0, 1'b0, 1'b0);
    op(32'h20, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0); collect("dst0", 10);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_param.md
Name: mem_wb_stage_param

Overview:
- Parametrised successor of the MEM/WB pipeline stage: data memory plus the MEM/WB pipeline register.
- Adds configurable data width and memory depth, and byte/half/word/double loads and stores with sign or zero extension.
- Adds a configurable multi-cycle memory latency, with a busy handshake, flush, misalignment detection and an internal write-back mux.
- Sits between EX/MEM and the register file write port; its outputs drive the register file and the forwarding unit.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- ADDR_W, 10, word-address bits; memory depth is 2^ADDR_W words.
- REG_ADDR_W, 5, register-file index width.
- MEM_LAT, 0, extra wait cycles per memory access; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- alu_out  in  DATA_W  ALU result; byte address for memory ops.
- store_data  in  DATA_W  store data, right-aligned.
- reg_dst  in  REG_ADDR_W  destination register.
- reg_write  in  1  instruction writes the register file.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_to_reg  in  1  write-back selects load data (else alu_out).
- mem_size  in  2  00 byte, 01 half, 10 word, 11 double.
- mem_unsigned  in  1  zero-extend loads (else sign-extend).
- flush  in  1  synchronous kill of the in-flight instruction.
- busy  out  1  stage is waiting on memory; upstream must hold its inputs stable.
- wb_valid  out  1  write-back registers hold a valid instruction.
- wb_data  out  DATA_W  write-back data.
- wb_reg_dst  out  REG_ADDR_W  write-back register.
- wb_reg_write  out  1  register-file write enable.
- misalign_err  out  1  one-cycle pulse with the faulting instruction.

Behaviour:
- Reset (rst=0, async):
  - wb_valid, wb_data, wb_reg_dst, wb_reg_write and misalign_err go to 0.
  - FSM goes to IDLE; wait counter goes to 0.
  - Memory contents are not reset.
- FSM states IDLE and WAIT; busy = (state==WAIT), combinational.
- Accept: in IDLE with in_valid=1 and flush=0.
- Address mapping:
  - Lane bits L = log2(DATA_W/8).
  - Word index = alu_out[ADDR_W+L-1:L]; higher bits are ignored, so addresses wrap modulo depth.
  - Byte offset = alu_out[L-1:0].
- Misalignment:
  - Half with addr[0]≠0, word with addr[1:0]≠0, or double with addr[2:0]≠0 is misaligned.
  - Size 11 when DATA_W=32 is also an error.
  - On a misaligned mem op: no memory access; next edge wb_valid=1, wb_reg_write=0, misalign_err=1.
- Non-memory instruction, or MEM_LAT=0:
  - Completes at the next edge: wb_* are loaded and wb_valid=1.
  - A store commits on that same edge.
  - Loads read combinationally from the current array contents.
- Memory instruction with MEM_LAT>0:
  - Accept edge: latch the whole request, counter<=MEM_LAT, state<=WAIT, wb_valid<=0 (bubble).
  - In WAIT: counter decrements every edge.
  - The edge where counter==1: store commits / load data captured, wb_* loaded, wb_valid=1, state<=IDLE.
  - Accept-to-wb_valid latency is MEM_LAT+1 edges. in_valid is ignored while in WAIT.
- Store:
  - Byte enables cover size bytes starting at the offset; store_data low bytes are shifted to that lane.
  - Other bytes are unchanged.
- Load: the selected lanes are shifted down, then sign- or zero-extended to DATA_W per mem_unsigned.
- mem_read=1 together with mem_write=1: the store is performed, mem_to_reg is ignored and wb_data=alu_out.
- wb_reg_write = reg_write & ~err, and is forced to 0 when reg_dst==0.
- Flush (synchronous, beats everything except reset):
  - Next edge: wb_valid=0, wb_reg_write=0, misalign_err=0, state<=IDLE.
  - A pending uncommitted store is discarded; a simultaneous in_valid is dropped.
- Holding registers: when in IDLE with no accept, wb_valid<=0; wb_data and wb_reg_dst may hold their old values.

Decomposition:
- Package mem_wb_pkg holds:
  - size codes SZ_B/SZ_H/SZ_W/SZ_D;
  - the state encoding IDLE/WAIT;
  - a function mapping size to byte-enable mask;
  - a function for load extraction/extension.
- One sub-module, data_mem_be: byte-enable synchronous-write, asynchronous-read memory, parametrised by DATA_W and ADDR_W.

Test Plan:
- MEM_LAT=0, DATA_W=32:
  - Store word 0xDEADBEEF at 0x10, then load-word 0x10 with mem_to_reg=1, reg_dst=5.
  - Next edge: wb_data=0xDEADBEEF, wb_reg_dst=5, wb_reg_write=1.
- Byte/half extension:
  - Load-byte at 0x13 with sign extension → 0xFFFFFFDE; with mem_unsigned=1 → 0x000000DE.
  - Load-half at 0x12 → 0xFFFFDEAD.
- Misaligned store:
  - Store-word at 0x11 → misalign_err=1 and wb_reg_write=0 for one cycle.
  - A following load-word at 0x10 still returns 0xDEADBEEF.
- MEM_LAT=3:
  - busy is high for exactly 3 cycles after the accept edge; wb_valid rises on the 4th edge.
  - A second instruction held on the inputs is accepted the cycle busy falls.
- Flush during WAIT (MEM_LAT=3): store 0x12345678 at 0x20, assert flush in the 2nd wait cycle.
  - Result: wb_valid stays 0, state returns to IDLE, and a later load at 0x20 returns the old value.
- Reset mid-WAIT (async rst low): all outputs are 0 immediately and busy=0; reg_dst=0 with reg_write=1 yields wb_reg_write=0.
